// File: rtl/reflet_hardware_info_ext.sv
// reflet_hardware_info_ext
// Hardware-information peripheral: a 16-byte memory-mapped window reporting
// build-time configuration (clock in kHz, peripheral enables, word size,
// hardware version), plus a scratch byte and a free-running millisecond
// uptime counter with a coherent snapshot, run/clear control and a sticky
// overflow flag.
//
// Ports:
//   clk       in   system clock
//   reset     in   synchronous active-low reset
//   enable    in   bus access strobe
//   addr      in   byte address (base_addr_size bits)
//   write_en  in   1 = write, 0 = read (qualified by enable)
//   data_in   in   write data, bits [7:0] used
//   data_out  out  combinational read data, zero when not selected
module reflet_hardware_info_ext #(
  parameter int unsigned                wordsize       = 16,
  parameter int unsigned                base_addr_size = 16,
  parameter logic [base_addr_size-1:0]  base_addr      = 16'hFF00,
  parameter int                         enable_exti    = 1,
  parameter int                         enable_gpio    = 1,
  parameter int                         enable_timer   = 1,
  parameter int                         enable_uart    = 1,
  parameter int                         enable_pwm     = 1,
  parameter int unsigned                clk_freq       = 1000000,
  parameter logic [7:0]                 hw_version     = 8'h02
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [base_addr_size-1:0] addr,
  input  logic                      write_en,
  input  logic [wordsize-1:0]       data_in,
  output logic [wordsize-1:0]       data_out
);

  localparam int unsigned ADDR_EXT_W = base_addr_size + 1;
  localparam int unsigned CNT_W      = 32;

  localparam logic [3:0] OFF_SCRATCH = 4'd7;
  localparam logic [3:0] OFF_CTRL    = 4'd12;
  localparam logic [3:0] OFF_STATUS  = 4'd13;
  localparam logic [3:0] OFF_UPTIME0 = 4'd8;

  // Word-size code reported in INFO1[2:0]
  function automatic logic [2:0] ws_code(input int unsigned w);
    case (w)
      8:       return 3'd1;
      16:      return 3'd2;
      32:      return 3'd3;
      64:      return 3'd4;
      128:     return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

  localparam logic [CNT_W-1:0] CLK_KHZ    = CNT_W'(clk_freq / 1000);
  localparam logic [CNT_W-1:0] PRESC_MAX  = CNT_W'(clk_freq / 1000 - 1);
  localparam logic [7:0]       INFO1      = {(|enable_pwm), (|enable_uart), (|enable_timer),
                                             (|enable_gpio), (|enable_exti), ws_code(wordsize)};
  localparam logic [ADDR_EXT_W-1:0] WIN_LO = {1'b0, base_addr};
  localparam logic [ADDR_EXT_W-1:0] WIN_HI = WIN_LO + ADDR_EXT_W'(16);

  logic [CNT_W-1:0] presc;
  logic [CNT_W-1:0] counter;
  logic [23:0]      shadow;
  logic [7:0]       scratch;
  logic             run;
  logic             ovf;

  logic             sel_c;
  logic [3:0]       offset_c;
  logic             wr_c;
  logic             capture_c;
  logic             clr_c;
  logic             tick_c;
  logic             ovf_set_c;
  logic             ovf_clr_c;
  logic [7:0]       rd_byte_c;

  // Address decode; extended by one bit so a window at the top of the map
  // does not wrap.
  assign sel_c     = enable && ({1'b0, addr} >= WIN_LO) && ({1'b0, addr} < WIN_HI);
  assign offset_c  = 4'(addr - base_addr);
  assign wr_c      = sel_c && write_en;
  assign capture_c = sel_c && !write_en && (offset_c == OFF_UPTIME0);
  assign clr_c     = wr_c && (offset_c == OFF_CTRL) && data_in[1];
  assign tick_c    = run && (presc == PRESC_MAX);
  // A wrap suppressed by CLR is not an overflow
  assign ovf_set_c = tick_c && !clr_c && (counter == '1);
  assign ovf_clr_c = wr_c && (offset_c == OFF_STATUS) && data_in[0];

  // Register state
  always_ff @(posedge clk) begin
    if (!reset) begin
      presc   <= '0;
      counter <= '0;
      shadow  <= '0;
      scratch <= '0;
      run     <= 1'b1;
      ovf     <= 1'b0;
    end else begin
      if (clr_c) begin
        presc   <= '0;
        counter <= '0;
      end else if (run) begin
        if (tick_c) begin
          presc   <= '0;
          counter <= counter + CNT_W'(1);
        end else begin
          presc <= presc + CNT_W'(1);
        end
      end

      if (ovf_set_c) begin
        ovf <= 1'b1;
      end else if (ovf_clr_c) begin
        ovf <= 1'b0;
      end

      // Upper bytes frozen alongside the live low byte read this cycle
      if (capture_c) begin
        shadow <= counter[31:8];
      end

      if (wr_c && (offset_c == OFF_SCRATCH)) begin
        scratch <= data_in[7:0];
      end

      if (wr_c && (offset_c == OFF_CTRL)) begin
        run <= data_in[0];
      end
    end
  end

  // Read mux
  always_comb begin
    rd_byte_c = 8'h00;
    case (offset_c)
      4'd0:  rd_byte_c = CLK_KHZ[7:0];
      4'd1:  rd_byte_c = CLK_KHZ[15:8];
      4'd2:  rd_byte_c = CLK_KHZ[23:16];
      4'd3:  rd_byte_c = CLK_KHZ[31:24];
      4'd4:  rd_byte_c = INFO1;
      4'd6:  rd_byte_c = hw_version;
      4'd7:  rd_byte_c = scratch;
      4'd8:  rd_byte_c = counter[7:0];
      4'd9:  rd_byte_c = shadow[7:0];
      4'd10: rd_byte_c = shadow[15:8];
      4'd11: rd_byte_c = shadow[23:16];
      4'd12: rd_byte_c = {7'b0, run};
      4'd13: rd_byte_c = {7'b0, ovf};
      default: rd_byte_c = 8'h00;
    endcase
  end

  always_comb begin
    data_out = '0;
    if (sel_c) begin
      data_out = wordsize'(rd_byte_c);
    end
  end

  // Upper data_in bits carry no meaning for byte registers
  if (wordsize > 8) begin : g_wide
    logic unused_data_hi;
    assign unused_data_hi = ^data_in[wordsize-1:8];
  end

endmodule

// File: tb/tb_reflet_hardware_info_ext.sv
// Testbench for reflet_hardware_info_ext with clk_freq = 4000 (4 cycles/ms).
// A reference model tracks elapsed running cycles and derives the uptime as
// elapsed/P, so the counter, wrap and snapshot expectations come from time
// arithmetic rather than from a prescaler/counter pair.
module tb_reflet_hardware_info_ext;

  localparam int unsigned CLK_FREQ = 4000;
  localparam longint unsigned P    = CLK_FREQ / 1000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [15:0] addr;
  logic        write_en;
  logic [15:0] data_in;
  logic [15:0] data_out;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  longint unsigned run_cycles;
  bit              m_run;
  bit              m_ovf;
  logic [23:0]     m_shadow;
  logic [7:0]      m_scratch;

  reflet_hardware_info_ext #(
    .wordsize(16), .base_addr_size(16), .base_addr(16'hFF00),
    .enable_exti(1), .enable_gpio(1), .enable_timer(1), .enable_uart(1), .enable_pwm(1),
    .clk_freq(CLK_FREQ), .hw_version(8'h02)
  ) dut (
    .clk(clk), .reset(reset_n), .enable(enable), .addr(addr),
    .write_en(write_en), .data_in(data_in), .data_out(data_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m_count();
    return 32'(run_cycles / P);
  endfunction

  function automatic logic [15:0] exp_read(input logic en, input logic [15:0] a);
    logic [31:0] c;
    logic [31:0] khz;
    logic [7:0]  b;
    if (!en || a < 16'hFF00 || a > 16'hFF0F) return 16'h0000;
    c   = m_count();
    khz = 32'(CLK_FREQ / 1000);
    case (a[3:0])
      4'd0:  b = khz[7:0];
      4'd1:  b = khz[15:8];
      4'd2:  b = khz[23:16];
      4'd3:  b = khz[31:24];
      4'd4:  b = {5'b11111, 3'd2};
      4'd6:  b = 8'h02;
      4'd7:  b = m_scratch;
      4'd8:  b = c[7:0];
      4'd9:  b = m_shadow[7:0];
      4'd10: b = m_shadow[15:8];
      4'd11: b = m_shadow[23:16];
      4'd12: b = {7'b0, m_run};
      4'd13: b = {7'b0, m_ovf};
      default: b = 8'h00;
    endcase
    return {8'h00, b};
  endfunction

  task automatic drive(input logic en, input logic wr, input logic [15:0] a, input logic [15:0] d);
    enable   = en;
    write_en = wr;
    addr     = a;
    data_in  = d;
  endtask

  // Advance one clock edge and apply the same edge to the model
  task automatic step();
    logic [31:0] old;
    logic        sel, wr, rd, clr, set;
    logic [3:0]  off;
    @(posedge clk);
    old = m_count();
    if (!reset_n) begin
      run_cycles = 0;
      m_run      = 1'b1;
      m_ovf      = 1'b0;
      m_shadow   = '0;
      m_scratch  = '0;
    end else begin
      sel = enable && addr >= 16'hFF00 && addr <= 16'hFF0F;
      off = addr[3:0];
      wr  = sel && write_en;
      rd  = sel && !write_en;
      clr = wr && off == 4'd12 && data_in[1];
      set = 1'b0;
      if (clr) run_cycles = 0;
      else if (m_run) begin
        run_cycles = run_cycles + 1;
        if (m_count() < old) set = 1'b1;
      end
      if (set) m_ovf = 1'b1;
      else if (wr && off == 4'd13 && data_in[0]) m_ovf = 1'b0;
      if (rd && off == 4'd8) m_shadow = old[31:8];
      if (wr && off == 4'd7) m_scratch = data_in[7:0];
      if (wr && off == 4'd12) m_run = data_in[0];
    end
    #1;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] want [0:6];
    logic [15:0] e;
    want[0] = 8'h04; want[1] = 8'h00; want[2] = 8'h00; want[3] = 8'h00;
    want[4] = 8'hFA; want[5] = 8'h00; want[6] = 8'h02;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b0, 16'hFF00 + 16'(i), 16'h0000);
      #1;
      n_checks++;
      if (data_out !== {8'h00, want[i]})
        $display("FAIL reset_const[%0d]: got %h expected %h", i, data_out, {8'h00, want[i]});
      else n_pass++;
      step();
    end
    for (int i = 7; i < 14; i++) begin
      drive(1'b1, 1'b0, 16'hFF00 + 16'(i), 16'h0000);
      #1;
      e = exp_read(1'b1, addr);
      n_checks++;
      if (data_out !== e) $display("FAIL reset_state[%0d]: got %h expected %h", i, data_out, e);
      else n_pass++;
      step();
    end
    drive(1'b1, 1'b0, 16'hFF10, 16'h0000);
    #1;
    n_checks++;
    if (data_out !== 16'h0000) $display("FAIL outside_window: got %h expected 0000", data_out);
    else n_pass++;
    drive(1'b0, 1'b0, 16'hFF00, 16'h0000);
    #1;
    n_checks++;
    if (data_out !== 16'h0000) $display("FAIL not_enabled: got %h expected 0000", data_out);
    else n_pass++;
    step();
  endtask

  task automatic test_scratch();
    logic [7:0] v;
    drive(1'b1, 1'b1, 16'hFF07, 16'hFFA5);
    step();
    drive(1'b1, 1'b0, 16'hFF07, 16'h0000);
    #1;
    n_checks++;
    if (data_out !== 16'h00A5) $display("FAIL scratch_a5: got %h expected 00a5", data_out);
    else n_pass++;
    step();
    drive(1'b1, 1'b1, 16'hFF00, 16'h0011);
    step();
    drive(1'b1, 1'b0, 16'hFF00, 16'h0000);
    #1;
    n_checks++;
    if (data_out !== 16'h0004) $display("FAIL ro_write_ignored: got %h expected 0004", data_out);
    else n_pass++;
    step();
    for (int i = 0; i < 8; i++) begin
      v = 8'($urandom);
      drive(1'b1, 1'b1, 16'hFF07, {8'($urandom), v});
      step();
      drive(1'b1, 1'b0, 16'hFF07, 16'h0000);
      #1;
      n_checks++;
      if (data_out !== exp_read(1'b1, 16'hFF07))
        $display("FAIL scratch_rand: got %h expected %h", data_out, exp_read(1'b1, 16'hFF07));
      else n_pass++;
      step();
    end
    do_reset();
    drive(1'b1, 1'b0, 16'hFF07, 16'h0000);
    #1;
    n_checks++;
    if (data_out !== 16'h0000) $display("FAIL scratch_reset: got %h expected 0000", data_out);
    else n_pass++;
    step();
  endtask

  task automatic test_uptime();
    logic [15:0] a, e;
    do_reset();
    idle(1200);
    drive(1'b1, 1'b0, 16'hFF08, 16'h0000);
    #1;
    n_checks++;
    if (data_out !== 16'h002C) $display("FAIL uptime0_300: got %h expected 002c", data_out);
    else n_pass++;
    step();
    drive(1'b1, 1'b0, 16'hFF09, 16'h0000);
    #1;
    n_checks++;
    if (data_out !== 16'h0001) $display("FAIL uptime1_300: got %h expected 0001", data_out);
    else n_pass++;
    step();
    idle(2000);
    drive(1'b1, 1'b0, 16'hFF09, 16'h0000);
    #1;
    n_checks++;
    if (data_out !== 16'h0001) $display("FAIL shadow_held: got %h expected 0001", data_out);
    else n_pass++;
    step();
    for (int i = 0; i < 20; i++) begin
      idle(int'($urandom_range(0, 60)));
      a = 16'hFF08 + 16'($urandom_range(0, 3));
      drive(1'b1, 1'b0, a, 16'h0000);
      #1;
      e = exp_read(1'b1, a);
      n_checks++;
      if (data_out !== e) $display("FAIL uptime_rand @%h: got %h expected %h", a, data_out, e);
      else n_pass++;
      step();
    end
  endtask

  task automatic test_control();
    logic [15:0] e;
    drive(1'b1, 1'b1, 16'hFF0C, 16'h0000);
    step();
    idle(100);
    drive(1'b1, 1'b0, 16'hFF08, 16'h0000);
    #1;
    e = exp_read(1'b1, 16'hFF08);
    n_checks++;
    if (data_out !== e) $display("FAIL run0_frozen: got %h expected %h", data_out, e);
    else n_pass++;
    step();
    drive(1'b1, 1'b0, 16'hFF0C, 16'h0000);
    #1;
    n_checks++;
    if (data_out !== 16'h0000) $display("FAIL ctrl_run0: got %h expected 0000", data_out);
    else n_pass++;
    step();
    drive(1'b1, 1'b1, 16'hFF0C, 16'h0003);
    step();
    drive(1'b1, 1'b0, 16'hFF08, 16'h0000);
    #1;
    n_checks++;
    if (data_out !== 16'h0000) $display("FAIL clr_counter: got %h expected 0000", data_out);
    else n_pass++;
    step();
    idle(3);
    drive(1'b1, 1'b0, 16'hFF08, 16'h0000);
    #1;
    n_checks++;
    if (data_out !== 16'h0001) $display("FAIL first_tick: got %h expected 0001", data_out);
    else n_pass++;
    step();
    drive(1'b1, 1'b0, 16'hFF0C, 16'h0000);
    #1;
    n_checks++;
    if (data_out !== 16'h0001) $display("FAIL ctrl_run1: got %h expected 0001", data_out);
    else n_pass++;
    step();
    // CLR issued on the cycle a tick would occur
    while (run_cycles % P != P - 1) step();
    drive(1'b1, 1'b1, 16'hFF0C, 16'h0003);
    step();
    drive(1'b1, 1'b0, 16'hFF08, 16'h0000);
    #1;
    n_checks++;
    if (data_out !== 16'h0000) $display("FAIL clr_over_tick: got %h expected 0000", data_out);
    else n_pass++;
    step();
  endtask

  task automatic force_near_wrap();
    force dut.counter = 32'hFFFF_FFFF;
    force dut.presc   = 32'd3;
    #1;
    release dut.counter;
    release dut.presc;
    run_cycles = 64'(32'hFFFF_FFFF) * P + (P - 1);
  endtask

  task automatic test_overflow();
    do_reset();
    idle(3);
    force_near_wrap();
    idle(1);
    drive(1'b1, 1'b0, 16'hFF0D, 16'h0000);
    #1;
    n_checks++;
    if (data_out !== 16'h0001) $display("FAIL ovf_set: got %h expected 0001", data_out);
    else n_pass++;
    step();
    drive(1'b1, 1'b0, 16'hFF08, 16'h0000);
    #1;
    n_checks++;
    if (data_out !== exp_read(1'b1, 16'hFF08) || data_out > 16'h0001)
      $display("FAIL wrap_count: got %h expected %h", data_out, exp_read(1'b1, 16'hFF08));
    else n_pass++;
    step();
    force_near_wrap();
    drive(1'b1, 1'b1, 16'hFF0D, 16'h0001);
    step();
    drive(1'b1, 1'b0, 16'hFF0D, 16'h0000);
    #1;
    n_checks++;
    if (data_out !== 16'h0001) $display("FAIL ovf_set_wins: got %h expected 0001", data_out);
    else n_pass++;
    step();
    drive(1'b1, 1'b1, 16'hFF0D, 16'h00FE);
    step();
    drive(1'b1, 1'b0, 16'hFF0D, 16'h0000);
    #1;
    n_checks++;
    if (data_out !== 16'h0001) $display("FAIL ovf_write0: got %h expected 0001", data_out);
    else n_pass++;
    step();
    drive(1'b1, 1'b1, 16'hFF0D, 16'h0001);
    step();
    drive(1'b1, 1'b0, 16'hFF0D, 16'h0000);
    #1;
    n_checks++;
    if (data_out !== 16'h0000) $display("FAIL ovf_clear: got %h expected 0000", data_out);
    else n_pass++;
    step();
  endtask

  task automatic test_back_to_back();
    logic [15:0] e;
    idle(int'($urandom_range(300, 700)));
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 16'hFF08, 16'h0000);
      #1;
      e = exp_read(1'b1, 16'hFF08);
      n_checks++;
      if (data_out !== e) $display("FAIL b2b_live[%0d]: got %h expected %h", i, data_out, e);
      else n_pass++;
      step();
      idle(int'($urandom_range(0, 5)));
      drive(1'b1, 1'b0, 16'hFF08, 16'h0000);
      step();
      drive(1'b1, 1'b0, 16'hFF09, 16'h0000);
      #1;
      e = exp_read(1'b1, 16'hFF09);
      n_checks++;
      if (data_out !== e) $display("FAIL b2b_shadow[%0d]: got %h expected %h", i, data_out, e);
      else n_pass++;
      step();
    end
    // Reset on the same edge as a capture request discards the capture
    drive(1'b1, 1'b0, 16'hFF08, 16'h0000);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    drive(1'b1, 1'b0, 16'hFF09, 16'h0000);
    #1;
    n_checks++;
    if (data_out !== 16'h0000) $display("FAIL reset_drops_capture: got %h expected 0000", data_out);
    else n_pass++;
    step();
  endtask

  task automatic test_random();
    logic [15:0] a, d, e;
    logic        en;
    int          op;
    for (int i = 0; i < 400; i++) begin
      op = int'($urandom_range(0, 9));
      a  = 16'hFEF8 + 16'($urandom_range(0, 31));
      en = ($urandom_range(0, 7) != 0);
      d  = 16'($urandom);
      if (op < 2) begin
        idle(int'($urandom_range(1, 9)));
      end else if (op < 4) begin
        // Bias writes toward the writable offsets; avoid frequent stops
        if (op == 2) a = 16'hFF07 + 16'($urandom_range(0, 6) == 0 ? 5 : 0);
        if (a == 16'hFF0C) d[0] = 1'b1;
        drive(en, 1'b1, a, d);
        #1;
        n_checks++;
        if (data_out !== exp_read(en, a))
          $display("FAIL rand_wr_out @%h: got %h expected %h", a, data_out, exp_read(en, a));
        else n_pass++;
        step();
      end else begin
        drive(en, 1'b0, a, 16'h0000);
        #1;
        e = exp_read(en, a);
        n_checks++;
        if (data_out !== e) $display("FAIL rand_rd @%h en=%0b: got %h expected %h", a, en, data_out, e);
        else n_pass++;
        step();
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    run_cycles = 0;
    m_run      = 1'b1;
    m_ovf      = 1'b0;
    m_shadow   = '0;
    m_scratch  = '0;
    @(negedge clk);
    test_reset();
    test_scratch();
    test_uptime();
    test_control();
    test_overflow();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reflet_hardware_info_ext.md
# reflet_hardware_info_ext

Extended, parametrised hardware-information peripheral for the Reflet microcontroller's peripheral address space. It exposes build-time configuration through a 16-byte memory-mapped window: clock frequency, peripheral enables, word size and hardware version. It also provides a writable scratch byte and a free-running millisecond uptime counter with a coherent multi-byte snapshot, control and sticky overflow status. It sits on the same peripheral bus as the other Reflet peripherals and takes the same configuration parameters as the periph module.

## Interface
- `wordsize`, 16, CPU word width; `data_in`/`data_out` width.
- `base_addr_size`, 16, address bus width.
- `base_addr`, 16'hFF00, first byte of the 16-byte window.
- `enable_exti`, `enable_gpio`, `enable_timer`, `enable_uart`, `enable_pwm`, 1 each, peripheral-present flags; reported as the OR of each value.
- `clk_freq`, 1000000, clock in Hz; must be ≥1000.
- `hw_version`, 8'h02, constant reported at offset 6.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-low reset.
- `enable`  in  1  bus access strobe.
- `addr`  in  base_addr_size  byte address.
- `write_en`  in  1  1 = write, 0 = read; only meaningful when `enable` is high.
- `data_in`  in  wordsize  write data; only bits [7:0] are used.
- `data_out`  out  wordsize  read data; zero when not selected.

## Operation
- Selected when `enable` is high and base_addr ≤ addr < base_addr+16; offset = addr − base_addr (4 bits).
- Register map (byte registers; data_out[7:0] carries the byte, upper bits are 0):
  - 0–3 CLK_KHZ: (clk_freq/1000), 32-bit, little-endian. Read-only.
  - 4 INFO1: {|enable_pwm, |enable_uart, |enable_timer, |enable_gpio, |enable_exti, ws[2:0]}, where ws = 1/2/3/4/5 for wordsize 8/16/32/64/128, otherwise 0. Read-only.
  - 5 INFO2: 0, reserved. Read-only.
  - 6 VERSION: hw_version. Read-only.
  - 7 SCRATCH: read/write, reset 0.
  - 8 UPTIME0: read returns the live counter[7:0].
    - A read of offset 8 also captures counter[31:8] into the shadow register at the next clock edge.
  - 9–11 UPTIME1–3: read returns shadow[7:0], [15:8], [23:16]. Read-only.
  - 12 CTRL: bit0 RUN (reset 1), read/write.
    - bit1 CLR: write-1 action, always reads 0.
    - Other bits read 0.
  - 13 STATUS: bit0 OVF sticky. Write 1 to bit0 clears it; other bits read 0.
  - 14–15: read 0.
- Writes to read-only or reserved offsets are ignored.
- Reads are combinational (same cycle as `enable`/`addr`). No bus wait states.
- Prescaler: width 32, counts 0..P−1 where P = clk_freq/1000, advancing only while RUN = 1. At count P−1 it returns to 0 and generates a tick; the tick increments the 32-bit uptime counter.
- Uptime counter wraps from FFFFFFFF to 0 on a tick. The wrap sets OVF.
- CLR write: prescaler and counter become 0 at that edge. CLR has priority over a tick in the same cycle. The shadow register and OVF are unaffected.
- OVF set and a write-1-clear in the same cycle: set wins.
- RUN = 0 freezes the prescaler and the counter; they resume from their frozen values when RUN returns to 1.
- Snapshot coherency: the live byte 0 read at cycle N and the shadow captured at the edge ending cycle N come from the same counter value.

## Timing
- Reset (reset = 0 at a clock edge): prescaler = 0, counter = 0, shadow = 0, SCRATCH = 0, RUN = 1, OVF = 0.
  - `data_out` stays combinational; reads return the reset values on the following cycle.
- A write takes effect at the edge ending the `enable && write_en` cycle; the new value is readable in the next cycle.
- First tick occurs P cycles after reset release, i.e. the counter reads 1 after P rising edges with RUN = 1.
- Reset mid-operation discards any pending capture or clear; all state returns to reset values at that edge.
- Back-to-back reads of offset 8 recapture the shadow every cycle.

## Test plan
- Setup: clk_freq = 4000 (P = 4), wordsize = 16, base_addr = 16'hFF00.
- After reset, read FF00..FF06 → 04, 00, 00, 00, 0xFA (INFO1 with all enables set and ws = 2), 00, 02. Read FF10 → 0000.
- Scratch: write 0xA5 to FF07 → reads A5. Write 0x11 to FF00 → FF00 still reads 04. Assert reset → FF07 reads 00.
- Uptime: after reset, run 4·300 = 1200 cycles, read FF08 then FF09 → 0x2C, 0x01. Continue counting, then read FF09 again without rereading FF08 → still 0x01 (shadow held).
- Control: write CTRL = 0 and wait 100 cycles → counter unchanged. Write CTRL = 3 → counter reads 0 next cycle and RUN = 1. Then 4 cycles → counter = 1.
- Overflow: force the counter to FFFFFFFF with the prescaler at 3 (hierarchical force or long run) → next edge gives counter = 0 and STATUS = 01. Write 1 to FF0D on the same cycle as another wrap → STATUS stays 01. A later write of 1 → STATUS = 00.
